uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Next-generation UART transmitter for the peripheral bus. It adds a DEPTH-entry transmit FIFO, a runtime baud divider, selectable parity (none/even/odd) and 1 or 2 stop bits. The CPU-side register block writes bytes into the FIFO, and frames are serialised onto uart_txd back-to-back without idle gaps. It replaces fixed-rate, single-buffer transmitters wherever software must change baud rate or frame format.

Parameters:
PAYLOAD_BITS, 8, data bits per frame (5..8), sent LSB first
FIFO_DEPTH, 4, FIFO entries (power of 2, >= 2)
DIV_W, 16, width of divider input

Ports:
clk  input  1  system clock
resetn  input  1  synchronous, active-low reset
wr_en  input  1  push wr_data into FIFO when wr_ready=1
wr_data  input  PAYLOAD_BITS  byte to transmit
wr_ready  output  1  FIFO not full (combinational from count)
overflow  output  1  one-cycle pulse: wr_en while full, data dropped
divider  input  DIV_W  cycles per bit minus 1
parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none
two_stop  input  1  1 = two stop bits
fifo_level  output  $clog2(FIFO_DEPTH+1)  entries held in the FIFO (0..FIFO_DEPTH)
tx_busy  output  1  FSM not IDLE
tx_idle  output  1  FIFO empty and not busy
uart_txd  output  1  serial line, registered, idle high

Behaviour:
- Reset (resetn=0 at posedge): uart_txd=1, tx_busy=0, fifo_level=0, wr_ready=1, overflow=0, tx_idle=1, FSM=IDLE. FIFO is flushed. A reset mid-frame forces txd high on that edge; the partial frame is abandoned.
- FIFO:
  - A push occurs on wr_en && wr_ready.
  - A pop occurs when the FSM loads a frame.
  - A simultaneous push and pop leaves the level unchanged.
  - Write while full: data dropped, level unchanged, overflow=1 for the next cycle only. A pop on that same edge does not rescue the write.
  - Pointers wrap modulo FIFO_DEPTH.
- Frame load:
  - Trigger: FSM is IDLE, or is at the final cycle of the last stop bit, and the FIFO is non-empty.
  - On that edge: pop the head entry; latch the data, divider, parity_mode and two_stop; drive txd<=0; enter START with bit counter 0.
  - Latched configuration holds for the whole frame. Input changes mid-frame affect only the next frame.
- Latency: a write to an empty FIFO in IDLE at edge E0 gives txd low after E1. tx_busy rises at E1. fifo_level is 1 after E0 and 0 after E1.
- States: IDLE -> START -> DATA (PAYLOAD_BITS bits) -> PARITY (only if parity enabled) -> STOP1 -> STOP2 (only if two_stop) -> IDLE or START.
- Each bit lasts exactly divider+1 cycles. divider=0 gives 1 cycle per bit.
- The cycle counter is DIV_W wide. It clears at each bit boundary and holds at 0 in IDLE.
- Frame length = (1 + PAYLOAD_BITS + P + S) * (divider+1) cycles, where P is 0/1 and S is 1/2.
- txd values:
  - DATA: shift register LSB, shifted right at each bit boundary.
  - Parity bit: XOR of the data bits for even; its inverse for odd.
  - STOP and IDLE: 1.
- All txd changes are registered: no glitches, no combinational path from inputs to uart_txd.
- Back-to-back: if the FIFO is non-empty at the end of the final stop bit, the next start bit begins on the immediately following cycle. tx_busy stays 1 throughout.
- tx_busy falls on the edge that returns the FSM to IDLE. tx_idle = (fifo_level==0) && !tx_busy.

Test Plan:
- divider=3, parity none, 1 stop, write 0xA5 while idle -> txd low 1 cycle after write. Then 4-cycle bits 0,1,0,1,0,0,1,0,1,1 (40 cycles total); tx_busy high for exactly 40 cycles.
- divider=3, parity even, then odd, data 0xA5 (four ones) -> parity bit 0 for even, 1 for odd. Each frame is 44 cycles.
- divider=1, two_stop=1, parity none, 0x00 -> 11 bit-times of 2 cycles. txd is 0 for 18 cycles, then 1 for 4 cycles.
- divider=7, six consecutive writes 0x00..0x05 starting from idle -> first five accepted (one popped immediately). Sixth dropped with overflow pulsed 1 cycle. wr_ready low while fifo_level=4. Frames 0x00..0x04 sent with no gap between stop and start bits.
- Change divider 3->9 and parity none->odd mid-frame -> current frame unchanged. The next queued frame uses 10-cycle bits with an odd parity bit.
- Assert resetn=0 for 1 cycle during the DATA bit 3 of a frame with 2 bytes queued -> txd=1 and fifo_level=0 after the reset edge. No further txd activity.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : UART transmitter with a transmit FIFO, runtime baud divider,
//            selectable parity and one or two stop bits.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int PAYLOAD_BITS = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int DIV_W        = 16
) (
    input  logic                               clk,
    input  logic                               resetn,
    input  logic                               wr_en,
    input  logic [PAYLOAD_BITS-1:0]            wr_data,
    output logic                               wr_ready,
    output logic                               overflow,
    input  logic [DIV_W-1:0]                   divider,
    input  logic [1:0]                         parity_mode,
    input  logic                               two_stop,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
    output logic                               tx_busy,
    output logic                               tx_idle,
    output logic                               uart_txd
);

    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int BC_W  = $clog2(PAYLOAD_BITS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    logic [PAYLOAD_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]        count_q;
    logic                    overflow_q;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        cnt_q, cnt_d;
    logic [BC_W-1:0]         bit_q, bit_d;
    logic [PAYLOAD_BITS-1:0] sh_q, sh_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic                    par_en_q, par_en_d;
    logic                    par_bit_q, par_bit_d;
    logic                    two_q, two_d;
    logic                    txd_q, txd_d;

    logic                    w_push, w_pop, w_bit_end, w_frame_end;
    logic [PAYLOAD_BITS-1:0] w_head;

    assign wr_ready   = (count_q != LVL_W'(FIFO_DEPTH));
    assign w_push     = wr_en && wr_ready;
    assign w_head     = mem_q[rd_ptr_q];
    assign overflow   = overflow_q;
    assign fifo_level = count_q;
    assign tx_busy    = (state_q != S_IDLE);
    assign tx_idle    = (count_q == '0) && (state_q == S_IDLE);
    assign uart_txd   = txd_q;

    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= wr_en && !wr_ready;
            if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (w_push && !w_pop)      count_q <= count_q + LVL_W'(1);
            else if (w_pop && !w_push) count_q <= count_q - LVL_W'(1);
        end
    end

    assign w_bit_end   = (cnt_q == div_q);
    // A new frame may load from idle or on the very last cycle of the last stop bit.
    assign w_frame_end = (state_q == S_IDLE) ||
                         (w_bit_end && ((state_q == S_STOP2) ||
                                        ((state_q == S_STOP1) && !two_q)));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        div_d     = div_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        two_d     = two_q;
        txd_d     = txd_q;
        w_pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                txd_d = 1'b1;
            end
            S_START: begin
                if (w_bit_end) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                    txd_d   = sh_q[0];
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    cnt_d = '0;
                    sh_d  = sh_q >> 1;
                    if (bit_q == BC_W'(PAYLOAD_BITS - 1)) begin
                        state_d = par_en_q ? S_PARITY : S_STOP1;
                        txd_d   = par_en_q ? par_bit_q : 1'b1;
                    end else begin
                        bit_d = bit_q + BC_W'(1);
                        txd_d = sh_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_PARITY: begin
                if (w_bit_end) begin
                    cnt_d   = '0;
                    state_d = S_STOP1;
                    txd_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_STOP1: begin
                if (w_bit_end) begin
                    cnt_d   = '0;
                    state_d = two_q ? S_STOP2 : S_IDLE;
                    txd_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_STOP2: begin
                if (w_bit_end) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    txd_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                txd_d   = 1'b1;
            end
        endcase

        // Frame configuration is captured here and held until the next load.
        if (w_frame_end && (count_q != '0)) begin
            w_pop     = 1'b1;
            state_d   = S_START;
            cnt_d     = '0;
            bit_d     = '0;
            sh_d      = w_head;
            div_d     = divider;
            par_en_d  = (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_bit_d = (^w_head) ^ (parity_mode == 2'b10);
            two_d     = two_stop;
            txd_d     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            sh_q      <= '0;
            div_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            two_q     <= 1'b0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            div_q     <= div_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            two_q     <= two_d;
            txd_q     <= txd_d;
        end
    end

endmodule
`default_nettype wire
